// File: rtl/controle_multiciclo_if.sv
// Control/status bundle between the multi-cycle control unit and the MIPS32 datapath.
// master = control unit, slave = datapath/memory side.
interface controle_multiciclo_if #(
  parameter int unsigned CONT_W = 16
);
  logic              inicio;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              zero;
  logic              mem_pronto;
  logic              c_pc_escrever;
  logic              c_ir_escrever;
  logic              c_mem_ler;
  logic              c_mem_escrever;
  logic              c_iord;
  logic [1:0]        c_ALUOp;
  logic              c_fonte_ula_a;
  logic [1:0]        c_fonte_ula_b;
  logic [1:0]        c_fonte_pc;
  logic [1:0]        c_memtoreg;
  logic [1:0]        c_reg_destino;
  logic              c_escrever_reg;
  logic [3:0]        estado;
  logic              retirada;
  logic [CONT_W-1:0] cont_instr;
  logic              instr_invalida;
  logic              timeout_erro;

  modport master (
    input  inicio, opcode, funct, zero, mem_pronto,
    output c_pc_escrever, c_ir_escrever, c_mem_ler, c_mem_escrever, c_iord,
           c_ALUOp, c_fonte_ula_a, c_fonte_ula_b, c_fonte_pc, c_memtoreg,
           c_reg_destino, c_escrever_reg, estado, retirada, cont_instr,
           instr_invalida, timeout_erro
  );

  modport slave (
    output inicio, opcode, funct, zero, mem_pronto,
    input  c_pc_escrever, c_ir_escrever, c_mem_ler, c_mem_escrever, c_iord,
           c_ALUOp, c_fonte_ula_a, c_fonte_ula_b, c_fonte_pc, c_memtoreg,
           c_reg_destino, c_escrever_reg, estado, retirada, cont_instr,
           instr_invalida, timeout_erro
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS32 control unit: fetch/decode/execute/memory/writeback sequencing
// with memory-ready stalls, wait timeout, invalid-opcode trap and retirement counter.
module controle_multiciclo #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CONT_W  = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  controle_multiciclo_if.master bus
);

  localparam int unsigned ESPERA_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LIMITE   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    BUSCA      = 4'd1,
    DECODIFICA = 4'd2,
    END_MEM    = 4'd3,
    LER_MEM    = 4'd4,
    WB_MEM     = 4'd5,
    ESCR_MEM   = 4'd6,
    EXEC_R     = 4'd7,
    WB_R       = 4'd8,
    EXEC_I     = 4'd9,
    WB_I       = 4'd10,
    DESVIO     = 4'd11,
    SALTO      = 4'd12,
    JR         = 4'd13,
    ERRO       = 4'd15
  } estado_t;

  estado_t             r_estado;
  estado_t             w_prox;
  logic [ESPERA_W-1:0] r_espera;
  logic [CONT_W-1:0]   r_cont;
  logic                r_invalida;
  logic                r_timeout;
  logic                w_mem;
  logic                w_limite;
  logic                w_retirada;
  logic                w_invalida;
  logic                w_estouro;

  // A stalled access times out on the cycle its wait count would reach TIMEOUT;
  // a ready arriving on that same cycle still completes the access.
  assign w_mem    = (r_estado == BUSCA) || (r_estado == LER_MEM) || (r_estado == ESCR_MEM);
  assign w_limite = (TIMEOUT != 0) && (r_espera == ESPERA_W'(LIMITE)) && !bus.mem_pronto;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_estado <= OCIOSO;
    else          r_estado <= w_prox;
  end

  always_comb begin
    w_prox              = r_estado;
    w_retirada          = 1'b0;
    w_invalida          = 1'b0;
    w_estouro           = 1'b0;
    bus.c_pc_escrever   = 1'b0;
    bus.c_ir_escrever   = 1'b0;
    bus.c_mem_ler       = 1'b0;
    bus.c_mem_escrever  = 1'b0;
    bus.c_iord          = 1'b0;
    bus.c_ALUOp         = 2'b00;
    bus.c_fonte_ula_a   = 1'b0;
    bus.c_fonte_ula_b   = 2'b00;
    bus.c_fonte_pc      = 2'b00;
    bus.c_memtoreg      = 2'b00;
    bus.c_reg_destino   = 2'b00;
    bus.c_escrever_reg  = 1'b0;
    case (r_estado)
      OCIOSO: if (bus.inicio) w_prox = BUSCA;
      BUSCA: begin
        bus.c_mem_ler     = 1'b1;
        bus.c_fonte_ula_b = 2'b01;
        bus.c_ir_escrever = bus.mem_pronto;
        bus.c_pc_escrever = bus.mem_pronto;
        if (bus.mem_pronto) w_prox = DECODIFICA;
        else if (w_limite) begin
          w_prox    = ERRO;
          w_estouro = 1'b1;
        end
      end
      DECODIFICA: begin
        bus.c_fonte_ula_b = 2'b11;
        case (bus.opcode)
          OP_R:           w_prox = (bus.funct == FN_JR) ? JR : EXEC_R;
          OP_LW, OP_SW:   w_prox = END_MEM;
          OP_ADDI:        w_prox = EXEC_I;
          OP_BEQ, OP_BNE: w_prox = DESVIO;
          OP_J, OP_JAL:   w_prox = SALTO;
          default: begin
            w_prox     = ERRO;
            w_invalida = 1'b1;
          end
        endcase
      end
      END_MEM: begin
        bus.c_fonte_ula_a = 1'b1;
        bus.c_fonte_ula_b = 2'b10;
        w_prox = (bus.opcode == OP_SW) ? ESCR_MEM : LER_MEM;
      end
      LER_MEM: begin
        bus.c_mem_ler = 1'b1;
        bus.c_iord    = 1'b1;
        if (bus.mem_pronto) w_prox = WB_MEM;
        else if (w_limite) begin
          w_prox    = ERRO;
          w_estouro = 1'b1;
        end
      end
      WB_MEM: begin
        bus.c_escrever_reg = 1'b1;
        bus.c_memtoreg     = 2'b01;
        w_retirada         = 1'b1;
        w_prox             = BUSCA;
      end
      ESCR_MEM: begin
        bus.c_mem_escrever = 1'b1;
        bus.c_iord         = 1'b1;
        if (bus.mem_pronto) begin
          w_retirada = 1'b1;
          w_prox     = BUSCA;
        end else if (w_limite) begin
          w_prox    = ERRO;
          w_estouro = 1'b1;
        end
      end
      EXEC_R: begin
        bus.c_fonte_ula_a = 1'b1;
        bus.c_ALUOp       = 2'b10;
        w_prox            = WB_R;
      end
      WB_R: begin
        bus.c_escrever_reg = 1'b1;
        bus.c_reg_destino  = 2'b01;
        w_retirada         = 1'b1;
        w_prox             = BUSCA;
      end
      EXEC_I: begin
        bus.c_fonte_ula_a = 1'b1;
        bus.c_fonte_ula_b = 2'b10;
        w_prox            = WB_I;
      end
      WB_I: begin
        bus.c_escrever_reg = 1'b1;
        w_retirada         = 1'b1;
        w_prox             = BUSCA;
      end
      DESVIO: begin
        bus.c_fonte_ula_a = 1'b1;
        bus.c_ALUOp       = 2'b01;
        bus.c_fonte_pc    = 2'b01;
        bus.c_pc_escrever = ((bus.opcode == OP_BEQ) && bus.zero) ||
                            ((bus.opcode == OP_BNE) && !bus.zero);
        w_retirada        = 1'b1;
        w_prox            = BUSCA;
      end
      SALTO: begin
        bus.c_pc_escrever = 1'b1;
        bus.c_fonte_pc    = 2'b10;
        if (bus.opcode == OP_JAL) begin
          bus.c_escrever_reg = 1'b1;
          bus.c_reg_destino  = 2'b10;
          bus.c_memtoreg     = 2'b10;
        end
        w_retirada = 1'b1;
        w_prox     = BUSCA;
      end
      JR: begin
        bus.c_pc_escrever = 1'b1;
        bus.c_fonte_pc    = 2'b11;
        w_retirada        = 1'b1;
        w_prox            = BUSCA;
      end
      ERRO:    w_prox = ERRO;
      default: w_prox = ERRO;
    endcase
  end

  // Wait counter restarts on every state change; error flags are sticky until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_espera   <= '0;
      r_cont     <= '0;
      r_invalida <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_prox != r_estado)            r_espera <= '0;
      else if (w_mem && !bus.mem_pronto) r_espera <= r_espera + ESPERA_W'(1);
      if (w_retirada) r_cont     <= r_cont + CONT_W'(1);
      if (w_invalida) r_invalida <= 1'b1;
      if (w_estouro)  r_timeout  <= 1'b1;
    end
  end

  assign bus.estado         = r_estado;
  assign bus.retirada       = w_retirada;
  assign bus.cont_instr     = r_cont;
  assign bus.instr_invalida = r_invalida;
  assign bus.timeout_erro   = r_timeout;

endmodule
